// File: rtl/rx_board_pkg.sv
// Shared types, defaults and helpers for the receive-port selection controller.
package rx_board_pkg;

    localparam int NPORT_DEF       = 4;
    localparam int ERR_THR_DEF     = 3;
    localparam int HOLD_FRAMES_DEF = 4;
    localparam int ERR_CNT_W       = 3;
    localparam int HOLD_CNT_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACTIVE = 3'd1,
        ST_SWITCH = 3'd2,
        ST_HOLD   = 3'd3,
        ST_FAIL   = 3'd4
    } sel_state_t;

    function automatic int idx_w(input int nport);
        return (nport > 1) ? $clog2(nport) : 1;
    endfunction

    // A frame start restarts the count, keeping only an error seen in that same cycle.
    function automatic logic [ERR_CNT_W-1:0] err_cnt_next(
        input logic [ERR_CNT_W-1:0] cnt,
        input logic                 hit,
        input logic                 frame
    );
        logic [ERR_CNT_W-1:0] nxt;
        if (frame) begin
            nxt = {2'b00, hit};
        end else if (hit && (cnt != 3'd7)) begin
            nxt = cnt + 3'd1;
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_port_pick.sv
// Combinational round-robin finder: first healthy port after cur, wrapping back to cur itself.
module rr_port_pick
    import rx_board_pkg::*;
#(
    parameter int NPORT = NPORT_DEF,
    localparam int IW   = idx_w(NPORT)
) (
    input  logic [NPORT-1:0] port_ok,
    input  logic [IW-1:0]    cur,
    output logic             found,
    output logic [IW-1:0]    idx
);

    logic [IW-1:0] cand_s;

    // Scan from the farthest offset down so the nearest healthy port wins.
    always_comb begin
        found  = 1'b0;
        idx    = cur;
        cand_s = cur;
        for (int i = NPORT; i >= 1; i--) begin
            cand_s = cur + IW'(i);
            found  = found | port_ok[cand_s];
            idx    = port_ok[cand_s] ? cand_s : idx;
        end
    end

endmodule

// File: rtl/rx_port_sel_ctrl.sv
// Receive-port selection controller: round-robin failover with error threshold and hold-off.
// Optional manual override is compiled in with RX_PORT_SEL_MANUAL_EN.
module rx_port_sel_ctrl
    import rx_board_pkg::*;
#(
    parameter int NPORT       = NPORT_DEF,
    parameter int ERR_THR     = ERR_THR_DEF,
    parameter int HOLD_FRAMES = HOLD_FRAMES_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    c_done,
    input  logic                    ovp,
    input  logic [NPORT-1:0]        port_ok,
    input  logic [NPORT-1:0]        port_err_p,
    input  logic                    man_mode,
    input  logic [idx_w(NPORT)-1:0] man_sel,
    output logic [idx_w(NPORT)-1:0] sel_port,
    output logic                    sel_port_chngp,
    output logic                    all_fail
);

    localparam int IW = idx_w(NPORT);

    sel_state_t              state_r;
    sel_state_t              state_next_s;
    logic [IW-1:0]           sel_port_r;
    logic                    chngp_r;
    logic                    all_fail_r;
    logic [ERR_CNT_W-1:0]    err_cnt_r;
    logic [HOLD_CNT_W-1:0]   hold_cnt_r;

    logic                    found_s;
    logic [IW-1:0]           pick_idx_s;
    logic                    man_req_s;
    logic                    man_hold_s;
    logic [IW-1:0]           man_idx_s;
    logic                    cur_ok_s;
    logic                    err_hit_s;
    logic                    err_trip_s;
    logic                    hold_done_s;
    logic                    load_s;
    logic [IW-1:0]           load_idx_s;
    logic                    fail_set_s;
    logic                    fail_clr_s;
    logic                    hold_inc_s;

    rr_port_pick #(
        .NPORT   (NPORT)
    ) u_pick (
        .port_ok (port_ok),
        .cur     (sel_port_r),
        .found   (found_s),
        .idx     (pick_idx_s)
    );

`ifdef RX_PORT_SEL_MANUAL_EN
    assign man_hold_s = man_mode;
    assign man_req_s  = man_mode & ovp & (man_sel != sel_port_r);
    assign man_idx_s  = man_sel;
`else
    logic unused_man_s;
    assign unused_man_s = man_mode ^ (^man_sel);
    assign man_hold_s   = 1'b0;
    assign man_req_s    = 1'b0;
    assign man_idx_s    = sel_port_r;
`endif

    assign cur_ok_s    = port_ok[sel_port_r];
    assign err_hit_s   = port_err_p[sel_port_r];
    assign err_trip_s  = (err_cnt_r >= ERR_CNT_W'(ERR_THR));
    assign hold_done_s = ((hold_cnt_r + 4'd1) == HOLD_CNT_W'(HOLD_FRAMES));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a dropped c_done overrides everything.
    always_comb begin
        state_next_s = state_r;
        if (!c_done) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_SWITCH;
                end
                ST_ACTIVE: begin
                    if (man_req_s) begin
                        state_next_s = ST_HOLD;
                    end else if (!man_hold_s && (!cur_ok_s || err_trip_s)) begin
                        state_next_s = ST_SWITCH;
                    end else begin
                        state_next_s = ST_ACTIVE;
                    end
                end
                ST_SWITCH: begin
                    if (ovp && found_s) begin
                        state_next_s = ST_HOLD;
                    end else if (ovp && !man_hold_s) begin
                        state_next_s = ST_FAIL;
                    end else begin
                        state_next_s = ST_SWITCH;
                    end
                end
                ST_HOLD: begin
                    if (man_req_s) begin
                        state_next_s = ST_HOLD;
                    end else if (ovp && hold_done_s) begin
                        state_next_s = ST_ACTIVE;
                    end else begin
                        state_next_s = ST_HOLD;
                    end
                end
                ST_FAIL: begin
                    if (ovp && found_s) begin
                        state_next_s = ST_HOLD;
                    end else begin
                        state_next_s = ST_FAIL;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Output/action decode feeding the registered datapath.
    always_comb begin
        load_s     = 1'b0;
        load_idx_s = pick_idx_s;
        fail_set_s = 1'b0;
        fail_clr_s = 1'b0;
        hold_inc_s = 1'b0;
        if (!c_done) begin
            load_s = 1'b0;
        end else begin
            case (state_r)
                ST_ACTIVE: begin
                    if (man_req_s) begin
                        load_s     = 1'b1;
                        load_idx_s = man_idx_s;
                    end else begin
                        load_s = 1'b0;
                    end
                end
                ST_SWITCH: begin
                    if (ovp && found_s) begin
                        load_s = 1'b1;
                    end else if (ovp && !man_hold_s) begin
                        fail_set_s = 1'b1;
                    end else begin
                        fail_set_s = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (man_req_s) begin
                        load_s     = 1'b1;
                        load_idx_s = man_idx_s;
                    end else begin
                        hold_inc_s = ovp;
                    end
                end
                ST_FAIL: begin
                    if (ovp && found_s) begin
                        load_s     = 1'b1;
                        fail_clr_s = 1'b1;
                    end else begin
                        fail_clr_s = 1'b0;
                    end
                end
                default: begin
                    load_s = 1'b0;
                end
            endcase
        end
    end

    // Selection, pulse, failure flag and frame/error counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_port_r <= {IW{1'b0}};
            chngp_r    <= 1'b0;
            all_fail_r <= 1'b0;
            err_cnt_r  <= 3'd0;
            hold_cnt_r <= 4'd0;
        end else begin
            chngp_r   <= load_s;
            err_cnt_r <= err_cnt_next(err_cnt_r, err_hit_s, ovp);
            if (load_s) begin
                sel_port_r <= load_idx_s;
            end else begin
                sel_port_r <= sel_port_r;
            end
            if (fail_set_s) begin
                all_fail_r <= 1'b1;
            end else if (fail_clr_s) begin
                all_fail_r <= 1'b0;
            end else begin
                all_fail_r <= all_fail_r;
            end
            if (load_s) begin
                hold_cnt_r <= 4'd0;
            end else if (hold_inc_s) begin
                hold_cnt_r <= hold_cnt_r + 4'd1;
            end else begin
                hold_cnt_r <= hold_cnt_r;
            end
        end
    end

    assign sel_port       = sel_port_r;
    assign sel_port_chngp = chngp_r;
    assign all_fail       = all_fail_r;

endmodule
